hb_rs_engine: RTL and testbench

- Parametrised Hummingbird-style running-state (RS) engine. Sits between the nonce source and the four-stage enc/dec datapaths.
- Loads four RS words from the nonce, then runs INIT_ROUNDS accumulation rounds and seeds an LFSR.
- Then updates separate encrypt and decrypt RS banks once per processed block.
- Beyond the previous generation: configurable word width, round count and LFSR taps; a stepping LFSR; independent enc/dec enables; re-nonce via start without reset.

---
 rtl/hb_rs_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_hb_rs_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_rs_engine.sv
// -----------------------------------------------------------------------------
// hb_rs_engine
//
// Running-state (RS) engine for a Hummingbird-style cipher. Sits between the
// nonce source and the four-stage encrypt/decrypt datapaths.
//
// Operation:
//   start  : encRS1..4 are loaded from nonce0..3 and INIT begins.
//   INIT   : INIT_ROUNDS cycles, each adding the encrypt stage outputs into
//            the encrypt RS words.
//   SEED   : one cycle; the LFSR is seeded from enc_data_out (never zero),
//            the decrypt bank is copied from the encrypt bank, rs_rdy rises.
//   RUN    : each data_valid cycle updates the enabled bank(s), steps the
//            LFSR once and pulses the matching *_complete output.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   start                         one-cycle pulse: load nonce, (re)start init
//   nonce0..nonce3      [W]       nonce words
//   enc_data_out, enc1_out,
//   enc2_out, enc3_out  [W]       encrypt datapath stage outputs
//   dec1_in, dec2_out, dec3_in [W] decrypt datapath stage values
//   data_valid                    one block processed this cycle
//   enc_en, dec_en                enable encrypt / decrypt bank update
//   encRS1..encRS4      [W]       encrypt RS (registered)
//   decRS1..decRS4      [W]       decrypt RS (registered)
//   lfsr                [W]       current LFSR value
//   rs_rdy                        RS valid (RUN state)
//   busy                          high while in INIT or SEED
//   enc_complete, dec_complete    one-cycle update-done pulses
// -----------------------------------------------------------------------------
module hb_rs_engine #(
   parameter int             W              = 16,
   parameter int             INIT_ROUNDS    = 4,
   parameter logic [W-1:0]   LFSR_SEED_MASK = W'(16'h1000),
   parameter logic [W-1:0]   LFSR_TAPS      = W'(16'hB400)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] nonce0,
   input  logic [W-1:0] nonce1,
   input  logic [W-1:0] nonce2,
   input  logic [W-1:0] nonce3,
   input  logic [W-1:0] enc_data_out,
   input  logic [W-1:0] enc1_out,
   input  logic [W-1:0] enc2_out,
   input  logic [W-1:0] enc3_out,
   input  logic [W-1:0] dec1_in,
   input  logic [W-1:0] dec2_out,
   input  logic [W-1:0] dec3_in,
   input  logic         data_valid,
   input  logic         enc_en,
   input  logic         dec_en,
   output logic [W-1:0] encRS1,
   output logic [W-1:0] encRS2,
   output logic [W-1:0] encRS3,
   output logic [W-1:0] encRS4,
   output logic [W-1:0] decRS1,
   output logic [W-1:0] decRS2,
   output logic [W-1:0] decRS3,
   output logic [W-1:0] decRS4,
   output logic [W-1:0] lfsr,
   output logic         rs_rdy,
   output logic         busy,
   output logic         enc_complete,
   output logic         dec_complete
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_SEED,
      ST_RUN
   } state_t;

   // Round counter is 4 bits wide: INIT_ROUNDS is limited to 1..15.
   localparam logic [3:0] LAST_ROUND = 4'(INIT_ROUNDS - 1);

   state_t         state_reg;
   logic [3:0]     round_cnt_reg;
   logic [W-1:0]   enc_rs_reg [4];
   logic [W-1:0]   dec_rs_reg [4];
   logic [W-1:0]   lfsr_reg;
   logic           rs_rdy_reg;
   logic           busy_reg;
   logic           enc_complete_reg;
   logic           dec_complete_reg;

   // Word-indexed views of the nonce and the init accumulation inputs.
   logic [W-1:0]   nonce_w    [4];
   logic [W-1:0]   init_in    [4];
   logic [W-1:0]   init_sum   [4];

   assign nonce_w[0] = nonce0;
   assign nonce_w[1] = nonce1;
   assign nonce_w[2] = nonce2;
   assign nonce_w[3] = nonce3;

   assign init_in[0] = enc_data_out;
   assign init_in[1] = enc1_out;
   assign init_in[2] = enc2_out;
   assign init_in[3] = enc3_out;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_init_sum
         assign init_sum[gi] = enc_rs_reg[gi] + init_in[gi];
      end
   endgenerate

   // RUN-state bank updates. Word 2 depends on the *new* word 4, so word 4 is
   // computed first and fed forward combinationally. All sums wrap mod 2^W.
   logic [W-1:0] enc_run1, enc_run2, enc_run3, enc_run4;
   logic [W-1:0] dec_run1, dec_run2, dec_run3, dec_run4;

   assign enc_run1 = enc_rs_reg[0] + enc3_out;
   assign enc_run4 = enc_rs_reg[3] + enc1_out + enc_rs_reg[0] + enc3_out;
   assign enc_run2 = enc_rs_reg[1] + enc1_out + enc_run4;
   assign enc_run3 = enc_rs_reg[2] + enc2_out + lfsr_reg;

   assign dec_run1 = dec_rs_reg[0] + dec3_in;
   assign dec_run4 = dec_rs_reg[3] + dec1_in + dec_rs_reg[0] + dec3_in;
   assign dec_run2 = dec_rs_reg[1] + dec1_in + dec_run4;
   assign dec_run3 = dec_rs_reg[2] + dec2_out + lfsr_reg;

   // Fibonacci LFSR: shift left, feedback is the parity of the tapped bits.
   logic [W-1:0] lfsr_step;
   assign lfsr_step = {lfsr_reg[W-2:0], ^(lfsr_reg & LFSR_TAPS)};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         round_cnt_reg    <= '0;
         lfsr_reg         <= '0;
         rs_rdy_reg       <= 1'b0;
         busy_reg         <= 1'b0;
         enc_complete_reg <= 1'b0;
         dec_complete_reg <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            enc_rs_reg[i] <= '0;
            dec_rs_reg[i] <= '0;
         end
      end else if (start) begin
         // start wins in every state: reload and restart init from scratch.
         for (int i = 0; i < 4; i++) begin
            enc_rs_reg[i] <= nonce_w[i];
         end
         round_cnt_reg    <= '0;
         state_reg        <= ST_INIT;
         busy_reg         <= 1'b1;
         rs_rdy_reg       <= 1'b0;
         enc_complete_reg <= 1'b0;
         dec_complete_reg <= 1'b0;
      end else begin
         // Completes are single-cycle pulses unless re-asserted in RUN.
         enc_complete_reg <= 1'b0;
         dec_complete_reg <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               busy_reg <= 1'b0;
            end

            ST_INIT: begin
               for (int i = 0; i < 4; i++) begin
                  enc_rs_reg[i] <= init_sum[i];
               end
               round_cnt_reg <= round_cnt_reg + 4'd1;
               if (round_cnt_reg == LAST_ROUND) begin
                  state_reg <= ST_SEED;
               end
            end

            ST_SEED: begin
               lfsr_reg <= enc_data_out | LFSR_SEED_MASK;
               for (int i = 0; i < 4; i++) begin
                  dec_rs_reg[i] <= enc_rs_reg[i];
               end
               rs_rdy_reg <= 1'b1;
               busy_reg   <= 1'b0;
               state_reg  <= ST_RUN;
            end

            ST_RUN: begin
               if (data_valid) begin
                  if (enc_en) begin
                     enc_rs_reg[0] <= enc_run1;
                     enc_rs_reg[1] <= enc_run2;
                     enc_rs_reg[2] <= enc_run3;
                     enc_rs_reg[3] <= enc_run4;
                  end
                  if (dec_en) begin
                     dec_rs_reg[0] <= dec_run1;
                     dec_rs_reg[1] <= dec_run2;
                     dec_rs_reg[2] <= dec_run3;
                     dec_rs_reg[3] <= dec_run4;
                  end
                  // One step per block; both banks above used the pre-step value.
                  if (enc_en || dec_en) begin
                     lfsr_reg <= lfsr_step;
                  end
                  enc_complete_reg <= enc_en;
                  dec_complete_reg <= dec_en;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign encRS1       = enc_rs_reg[0];
   assign encRS2       = enc_rs_reg[1];
   assign encRS3       = enc_rs_reg[2];
   assign encRS4       = enc_rs_reg[3];
   assign decRS1       = dec_rs_reg[0];
   assign decRS2       = dec_rs_reg[1];
   assign decRS3       = dec_rs_reg[2];
   assign decRS4       = dec_rs_reg[3];
   assign lfsr         = lfsr_reg;
   assign rs_rdy       = rs_rdy_reg;
   assign busy         = busy_reg;
   assign enc_complete = enc_complete_reg;
   assign dec_complete = dec_complete_reg;

endmodule

// File: tb/tb_hb_rs_engine.sv
// -----------------------------------------------------------------------------
// tb_hb_rs_engine
//
// Directed bench for hb_rs_engine (W=16, INIT_ROUNDS=4). Stimulus pushes the
// hand-computed expected RS/LFSR snapshot into a scoreboard queue; a monitor
// pops and compares whenever the DUT presents an event (rs_rdy rising,
// enc_complete or dec_complete). Reset state, busy timing and restart
// behaviour are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_hb_rs_engine;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] nonce0, nonce1, nonce2, nonce3;
   logic [15:0] enc_data_out, enc1_out, enc2_out, enc3_out;
   logic [15:0] dec1_in, dec2_out, dec3_in;
   logic        data_valid, enc_en, dec_en;
   logic [15:0] encRS1, encRS2, encRS3, encRS4;
   logic [15:0] decRS1, decRS2, decRS3, decRS4;
   logic [15:0] lfsr;
   logic        rs_rdy, busy, enc_complete, dec_complete;

   hb_rs_engine #(
      .W(16),
      .INIT_ROUNDS(4),
      .LFSR_SEED_MASK(16'h1000),
      .LFSR_TAPS(16'hB400)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .nonce0(nonce0), .nonce1(nonce1), .nonce2(nonce2), .nonce3(nonce3),
      .enc_data_out(enc_data_out), .enc1_out(enc1_out),
      .enc2_out(enc2_out), .enc3_out(enc3_out),
      .dec1_in(dec1_in), .dec2_out(dec2_out), .dec3_in(dec3_in),
      .data_valid(data_valid), .enc_en(enc_en), .dec_en(dec_en),
      .encRS1(encRS1), .encRS2(encRS2), .encRS3(encRS3), .encRS4(encRS4),
      .decRS1(decRS1), .decRS2(decRS2), .decRS3(decRS3), .decRS4(decRS4),
      .lfsr(lfsr), .rs_rdy(rs_rdy), .busy(busy),
      .enc_complete(enc_complete), .dec_complete(dec_complete)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       tag;
      logic [15:0] e1, e2, e3, e4;
      logic [15:0] d1, d2, d3, d4;
      logic [15:0] lf;
      logic        ec, dc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic rs_rdy_prev = 1'b0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic push(input string tag,
                       input logic [15:0] e1, e2, e3, e4,
                       input logic [15:0] d1, d2, d3, d4,
                       input logic [15:0] lf, input logic ec, input logic dc);
      exp_t x;
      x.tag = tag;
      x.e1 = e1; x.e2 = e2; x.e3 = e3; x.e4 = e4;
      x.d1 = d1; x.d2 = d2; x.d3 = d3; x.d4 = d4;
      x.lf = lf; x.ec = ec; x.dc = dc;
      sb.push_back(x);
   endtask

   // Monitor: one scoreboard entry per DUT event.
   always @(negedge clk) begin
      if ((rs_rdy && !rs_rdy_prev) || enc_complete || dec_complete) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got rs_rdy=%b enc_complete=%b dec_complete=%b expected none",
                     rs_rdy, enc_complete, dec_complete);
         end else begin
            exp_t x;
            x = sb.pop_front();
            $display("event %s: enc=%h %h %h %h dec=%h %h %h %h lfsr=%h ec=%b dc=%b",
                     x.tag, encRS1, encRS2, encRS3, encRS4,
                     decRS1, decRS2, decRS3, decRS4, lfsr, enc_complete, dec_complete);
            chk({x.tag, ".encRS1"}, encRS1, x.e1);
            chk({x.tag, ".encRS2"}, encRS2, x.e2);
            chk({x.tag, ".encRS3"}, encRS3, x.e3);
            chk({x.tag, ".encRS4"}, encRS4, x.e4);
            chk({x.tag, ".decRS1"}, decRS1, x.d1);
            chk({x.tag, ".decRS2"}, decRS2, x.d2);
            chk({x.tag, ".decRS3"}, decRS3, x.d3);
            chk({x.tag, ".decRS4"}, decRS4, x.d4);
            chk({x.tag, ".lfsr"}, lfsr, x.lf);
            chk({x.tag, ".enc_complete"}, {15'd0, enc_complete}, {15'd0, x.ec});
            chk({x.tag, ".dec_complete"}, {15'd0, dec_complete}, {15'd0, x.dc});
         end
      end
      rs_rdy_prev = rs_rdy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nonce(input logic [15:0] a, b, c, d);
      nonce0 = a; nonce1 = b; nonce2 = c; nonce3 = d;
   endtask

   task automatic set_enc(input logic [15:0] a, b, c, d);
      enc_data_out = a; enc1_out = b; enc2_out = c; enc3_out = d;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".encRS1"}, encRS1, 16'h0);
      chk({tag, ".encRS4"}, encRS4, 16'h0);
      chk({tag, ".decRS1"}, decRS1, 16'h0);
      chk({tag, ".decRS4"}, decRS4, 16'h0);
      chk({tag, ".lfsr"}, lfsr, 16'h0);
      chk({tag, ".flags"}, {12'd0, rs_rdy, busy, enc_complete, dec_complete}, 16'h0);
   endtask

   // Bounded wait for rs_rdy; an expired bound counts as a failed check.
   task automatic wait_rdy(input string tag);
      int n;
      n = 0;
      while (!rs_rdy && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!rs_rdy) begin
         errors++;
         $display("FAIL %s.timeout: got rs_rdy=0 expected 1 within 20 cycles", tag);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      set_nonce(16'h0, 16'h0, 16'h0, 16'h0);
      set_enc(16'h0, 16'h0, 16'h0, 16'h0);
      dec1_in = 16'h0; dec2_out = 16'h0; dec3_in = 16'h0;
      data_valid = 1'b0; enc_en = 1'b0; dec_en = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check_zero("reset");

      // data_valid in IDLE is ignored (monitor flags any complete).
      data_valid = 1'b1; enc_en = 1'b1; dec_en = 1'b1;
      tick();
      data_valid = 1'b0; enc_en = 1'b0; dec_en = 1'b0;
      chk("idle.lfsr", lfsr, 16'h0);

      // Init from nonce 1..4 with held stage outputs; busy/rs_rdy timing.
      set_nonce(16'h1, 16'h2, 16'h3, 16'h4);
      set_enc(16'h0010, 16'h0100, 16'h0200, 16'h0300);
      push("seed1", 16'h0041, 16'h0402, 16'h0803, 16'h0C04,
                    16'h0041, 16'h0402, 16'h0803, 16'h0C04, 16'h1010, 1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("load.encRS1", encRS1, 16'h0001);
      chk("load.busy_rdy", {14'd0, busy, rs_rdy}, 16'h0002);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("init_edge%0d.busy_rdy", i), {14'd0, busy, rs_rdy}, 16'h0002);
      end
      tick();
      chk("edge5.busy_rdy", {14'd0, busy, rs_rdy}, 16'h0001);

      // Encrypt-only block.
      push("enc1", 16'h0341, 16'h1547, 16'h1A13, 16'h1045,
                   16'h0041, 16'h0402, 16'h0803, 16'h0C04, 16'h2021, 1'b1, 1'b0);
      data_valid = 1'b1; enc_en = 1'b1;
      tick();
      data_valid = 1'b0; enc_en = 1'b0;
      tick();
      chk("enc1.pulse_end", {15'd0, enc_complete}, 16'h0);

      // Decrypt-only block.
      dec1_in = 16'h1; dec2_out = 16'h2; dec3_in = 16'h3;
      push("dec1", 16'h0341, 16'h1547, 16'h1A13, 16'h1045,
                   16'h0044, 16'h104C, 16'h2826, 16'h0C49, 16'h4043, 1'b0, 1'b1);
      data_valid = 1'b1; dec_en = 1'b1;
      tick();
      data_valid = 1'b0; dec_en = 1'b0;

      // Back-to-back blocks: both banks, then encrypt only.
      push("both", 16'h0641, 16'h2DCD, 16'h5C56, 16'h1786,
                   16'h0047, 16'h1CDE, 16'h686B, 16'h0C91, 16'h8086, 1'b1, 1'b1);
      push("enc2", 16'h0941, 16'h5094, 16'hDEDC, 16'h21C7,
                   16'h0047, 16'h1CDE, 16'h686B, 16'h0C91, 16'h010D, 1'b1, 1'b0);
      data_valid = 1'b1; enc_en = 1'b1; dec_en = 1'b1;
      tick();
      dec_en = 1'b0;
      tick();
      data_valid = 1'b0; enc_en = 1'b0;
      tick();
      chk("b2b.pulse_end", {14'd0, enc_complete, dec_complete}, 16'h0);

      // Both banks disabled: nothing moves.
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk("disabled.lfsr", lfsr, 16'h010D);
      chk("disabled.encRS2", encRS2, 16'h5094);

      // start in RUN together with data_valid; wrap-around during INIT.
      set_nonce(16'hFFFF, 16'h0010, 16'h0020, 16'h0030);
      set_enc(16'h0001, 16'h0100, 16'h0200, 16'h0300);
      push("seed_wrap", 16'h0003, 16'h0410, 16'h0820, 16'h0C30,
                        16'h0003, 16'h0410, 16'h0820, 16'h0C30, 16'h1001, 1'b0, 1'b0);
      start = 1'b1; data_valid = 1'b1; enc_en = 1'b1; dec_en = 1'b1;
      tick();
      start = 1'b0; data_valid = 1'b0; enc_en = 1'b0; dec_en = 1'b0;
      chk("restart.encRS1", encRS1, 16'hFFFF);
      chk("restart.encRS4", encRS4, 16'h0030);
      chk("restart.flags", {12'd0, rs_rdy, busy, enc_complete, dec_complete}, 16'h0004);
      wait_rdy("seed_wrap");

      // data_valid held through INIT/SEED is ignored.
      set_nonce(16'h1, 16'h2, 16'h3, 16'h4);
      set_enc(16'h0010, 16'h0100, 16'h0200, 16'h0300);
      push("seed_dv", 16'h0041, 16'h0402, 16'h0803, 16'h0C04,
                      16'h0041, 16'h0402, 16'h0803, 16'h0C04, 16'h1010, 1'b0, 1'b0);
      start = 1'b1; data_valid = 1'b1; enc_en = 1'b1; dec_en = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 5; i++) tick();
      data_valid = 1'b0; enc_en = 1'b0; dec_en = 1'b0;
      chk("seed_dv.rdy", {15'd0, rs_rdy}, 16'h1);

      // reset mid-INIT.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_zero("reset_mid_init");
      tick(); tick();
      chk("idle_after_reset.busy", {15'd0, busy}, 16'h0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
